snoop_bus_arbiter: RTL and testbench

Round-robin arbiter and sequencer for the shared snooping bus. The CPU front-ends each present a decoded bus command (write/read, 12-bit tag, 16-bit data). This block picks one requester and drives its command onto the single snoop bus. It holds the bus until the snooping caches/memory signal completion, then hands ownership to the next requester in rotation.

---
 rtl/snoop_bus_arbiter.sv | 162 ++++++++++++++++
 tb/tb_snoop_bus_arbiter.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/snoop_bus_arbiter.sv
// snoop_bus_arbiter
//   Round-robin arbiter and sequencer for the shared snooping bus. One CPU
//   front-end at a time owns the bus. Its decoded command is latched onto the
//   bus_* registers, and ownership is held until the snooping caches/memory
//   return snoop_done. Ownership then rotates past the previous owner.
//
// Optional feature macro: ARB_TIMEOUT_EN
//   When defined, a BUSY-cycle counter aborts a transaction after TIMEOUT
//   cycles without snoop_done. The abort pulses done and timeout_err together.
//   When undefined, BUSY waits forever and timeout_err stays 0.
//
// Ports
//   clock, reset    rising-edge clock; asynchronous active-high reset
//   req             level request per CPU, held until its done pulse
//   write_in/read_in command bits per CPU
//   tag_in/data_in  packed per-CPU tag/data (CPU i at [i*W +: W])
//   snoop_done      completion pulse, only honoured in BUSY
//   grant/done      one-hot ownership / one-cycle completion to the owner
//   bus_*           command presented on the snoop bus (valid when bus_valid)
//   bus_owner       index of the current owner
//   timeout_err     one-cycle abort flag
module snoop_bus_arbiter #(
  parameter int NUM_CPU = 3,
  parameter int TAG_W   = 12,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 15
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_CPU-1:0]        req,
  input  logic [NUM_CPU-1:0]        write_in,
  input  logic [NUM_CPU-1:0]        read_in,
  input  logic [NUM_CPU*TAG_W-1:0]  tag_in,
  input  logic [NUM_CPU*DATA_W-1:0] data_in,
  input  logic                      snoop_done,
  output logic [NUM_CPU-1:0]        grant,
  output logic [NUM_CPU-1:0]        done,
  output logic                      bus_valid,
  output logic                      bus_write,
  output logic                      bus_read,
  output logic [TAG_W-1:0]          bus_tag,
  output logic [DATA_W-1:0]         bus_data,
  output logic [$clog2(NUM_CPU)-1:0] bus_owner,
  output logic                      timeout_err
);

  localparam int OW = $clog2(NUM_CPU);

  if (NUM_CPU < 2 || NUM_CPU > 8 || TIMEOUT < 1) begin : g_param_err
    $error("snoop_bus_arbiter: NUM_CPU must be 2..8 and TIMEOUT >= 1");
  end

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_BUSY, S_DONE} state_t;

  state_t        state_q;
  logic [OW-1:0] last_owner_q;
  logic [OW-1:0] sel_d;
  logic          found;
  int unsigned   idx;

  // Rotating priority: scan last_owner+1, +2, ... wrapping modulo NUM_CPU.
  always_comb begin
    sel_d = last_owner_q;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= NUM_CPU; k++) begin
      idx = (int'(last_owner_q) + k) % NUM_CPU;
      if (!found && req[idx]) begin
        sel_d = OW'(idx);
        found = 1'b1;
      end
    end
  end

  // Owner's command slice. bus_owner is stable from GRANT onwards.
  logic              wr_s, rd_s;
  logic [TAG_W-1:0]  tag_s;
  logic [DATA_W-1:0] data_s;
  assign wr_s   = write_in[bus_owner];
  assign rd_s   = read_in[bus_owner];
  assign tag_s  = tag_in[bus_owner*TAG_W +: TAG_W];
  assign data_s = data_in[bus_owner*DATA_W +: DATA_W];

`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      last_owner_q <= OW'(NUM_CPU - 1);
      grant        <= '0;
      done         <= '0;
      bus_valid    <= 1'b0;
      bus_write    <= 1'b0;
      bus_read     <= 1'b0;
      bus_tag      <= '0;
      bus_data     <= '0;
      bus_owner    <= '0;
      timeout_err  <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      cnt_q        <= '0;
`endif
    end else begin
      // done/timeout_err are single-cycle pulses.
      done        <= '0;
      timeout_err <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (|req) begin
            grant     <= {{(NUM_CPU-1){1'b0}}, 1'b1} << sel_d;
            bus_owner <= sel_d;
            state_q   <= S_GRANT;
          end
        end
        S_GRANT: begin
          bus_write <= wr_s;
          bus_read  <= rd_s;
          bus_tag   <= tag_s;
          bus_data  <= data_s;
          if (wr_s ^ rd_s) begin
            bus_valid <= 1'b1;
            state_q   <= S_BUSY;
`ifdef ARB_TIMEOUT_EN
            cnt_q     <= '0;
`endif
          end else begin
            // Null command: skip the bus and complete straight away.
            done    <= grant;
            state_q <= S_DONE;
          end
        end
        S_BUSY: begin
          if (snoop_done) begin
            bus_valid <= 1'b0;
            done      <= grant;
            state_q   <= S_DONE;
          end
`ifdef ARB_TIMEOUT_EN
          // snoop_done in the final counted cycle takes priority above.
          else if (cnt_q == CW'(TIMEOUT - 1)) begin
            bus_valid   <= 1'b0;
            done        <= grant;
            timeout_err <= 1'b1;
            state_q     <= S_DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
`endif
        end
        S_DONE: begin
          grant        <= '0;
          last_owner_q <= bus_owner;
          state_q      <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_snoop_bus_arbiter.sv
// Scoreboard bench for snoop_bus_arbiter (NUM_CPU=3, TIMEOUT=4).
// Stimulus pushes expected grant / command / done events; a monitor turns
// DUT output edges into the same events and compares them in order.
module tb_snoop_bus_arbiter;

  logic        clock, reset;
  logic [2:0]  req, write_in, read_in;
  logic [35:0] tag_in;
  logic [47:0] data_in;
  logic        snoop_done;
  logic [2:0]  grant, done;
  logic        bus_valid, bus_write, bus_read;
  logic [11:0] bus_tag;
  logic [15:0] bus_data;
  logic [1:0]  bus_owner;
  logic        timeout_err;

  snoop_bus_arbiter #(.NUM_CPU(3), .TAG_W(12), .DATA_W(16), .TIMEOUT(4)) dut (
    .clock(clock), .reset(reset), .req(req), .write_in(write_in),
    .read_in(read_in), .tag_in(tag_in), .data_in(data_in),
    .snoop_done(snoop_done), .grant(grant), .done(done),
    .bus_valid(bus_valid), .bus_write(bus_write), .bus_read(bus_read),
    .bus_tag(bus_tag), .bus_data(bus_data), .bus_owner(bus_owner),
    .timeout_err(timeout_err));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct { int kind; logic [63:0] sig; } ev_t;  // 0 grant, 1 cmd, 2 done
  ev_t exq[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int gcyc = 0;
  int sd_delay = 0;
  int vcnt = 0;
  logic resp_sd = 1'b0;
  logic stray_sd = 1'b0;

  assign snoop_done = resp_sd | stray_sd;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_grant(input logic [2:0] g, input int o);
    exq.push_back('{0, 64'({g, 8'(o)})});
  endtask
  task automatic push_cmd(input logic w, input logic r, input logic [11:0] t, input logic [15:0] d);
    exq.push_back('{1, 64'({w, r, t, d})});
  endtask
  task automatic push_done(input logic [2:0] v, input int dl, input logic te);
    exq.push_back('{2, 64'({v, 8'(dl), te})});
  endtask

  task automatic set_cmd(input int c, input logic w, input logic r,
                         input logic [11:0] t, input logic [15:0] d);
    write_in[c] = w;
    read_in[c]  = r;
    tag_in[c*12 +: 12]  = t;
    data_in[c*16 +: 16] = d;
  endtask

  task automatic ev_check(input int kind, input logic [63:0] act);
    ev_t e;
    checks++;
    if (exq.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event got kind %0d sig %h expected none", kind, act);
    end else begin
      e = exq.pop_front();
      if (e.kind != kind || e.sig !== act) begin
        errors++;
        $display("FAIL event got kind %0d sig %h expected kind %0d sig %h",
                 kind, act, e.kind, e.sig);
      end
    end
  endtask

  // Monitor: output edges -> events.
  initial begin
    logic [2:0] pg;
    logic       pv;
    pg = '0;
    pv = 1'b0;
    forever begin
      @(negedge clock);
      if (pg == 3'b000 && grant != 3'b000) begin
        gcyc = cyc;
        ev_check(0, 64'({grant, 8'(bus_owner)}));
      end
      if (!pv && bus_valid)
        ev_check(1, 64'({bus_write, bus_read, bus_tag, bus_data}));
      if (done != 3'b000)
        ev_check(2, 64'({done, 8'(cyc - gcyc), timeout_err}));
      pg = grant;
      pv = bus_valid;
    end
  end

  // Responder: pulse snoop_done after sd_delay cycles of bus_valid (0 = never).
  initial begin
    forever begin
      @(negedge clock);
      if (bus_valid) begin
        vcnt++;
        resp_sd = (sd_delay != 0 && vcnt == sd_delay);
      end else begin
        vcnt = 0;
        resp_sd = 1'b0;
      end
    end
  end

  task automatic wait_done();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 80 && !seen; i++) begin
      @(negedge clock);
      if (done != 3'b000) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL wait_done got no done within 80 cycles expected done pulse");
    end
  endtask

  initial begin
    reset = 1'b1; req = '0; write_in = '0; read_in = '0;
    tag_in = '0; data_in = '0;
    repeat (2) @(negedge clock);
    #1;
    chk("rst_grant", 64'(grant), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_valid", 64'(bus_valid), 64'd0);
    chk("rst_owner", 64'(bus_owner), 64'd0);
    chk("rst_terr", 64'(timeout_err), 64'd0);
    chk("rst_cmd", 64'({bus_write, bus_read, bus_tag, bus_data}), 64'd0);
    @(negedge clock) reset = 1'b0;

    // Single write from CPU1, snoop_done 2 cycles into BUSY.
    set_cmd(1, 1'b1, 1'b0, 12'hABC, 16'h1234);
    sd_delay = 2;
    push_grant(3'b010, 1); push_cmd(1'b1, 1'b0, 12'hABC, 16'h1234); push_done(3'b010, 3, 1'b0);
    req = 3'b010;
    wait_done();
    req = 3'b000;
    repeat (3) @(negedge clock);

    // Fairness: all three requesting after a fresh reset.
    reset = 1'b1;
    @(negedge clock) reset = 1'b0;
    set_cmd(0, 1'b0, 1'b1, 12'h001, 16'h0A0A);
    set_cmd(1, 1'b1, 1'b0, 12'h002, 16'h1111);
    set_cmd(2, 1'b0, 1'b1, 12'h003, 16'h2222);
    sd_delay = 1;
    push_grant(3'b001, 0); push_cmd(1'b0, 1'b1, 12'h001, 16'h0A0A); push_done(3'b001, 2, 1'b0);
    push_grant(3'b010, 1); push_cmd(1'b1, 1'b0, 12'h002, 16'h1111); push_done(3'b010, 2, 1'b0);
    push_grant(3'b100, 2); push_cmd(1'b0, 1'b1, 12'h003, 16'h2222); push_done(3'b100, 2, 1'b0);
    push_grant(3'b001, 0); push_cmd(1'b0, 1'b1, 12'h001, 16'h0A0A); push_done(3'b001, 2, 1'b0);
    req = 3'b111;
    repeat (4) wait_done();
    req = 3'b000;
    repeat (3) @(negedge clock);

    // Null commands: neither bit (CPU0), both bits (CPU2).
    set_cmd(0, 1'b0, 1'b0, 12'h111, 16'h1111);
    set_cmd(2, 1'b1, 1'b1, 12'h222, 16'h2222);
    push_grant(3'b001, 0); push_done(3'b001, 1, 1'b0);
    req = 3'b001;
    wait_done();
    req = 3'b000;
    repeat (2) @(negedge clock);
    push_grant(3'b100, 2); push_done(3'b100, 1, 1'b0);
    req = 3'b100;
    wait_done();
    req = 3'b000;
    repeat (2) @(negedge clock);

    // Stray snoop_done in IDLE, then in GRANT: both ignored.
    stray_sd = 1'b1;
    repeat (2) @(negedge clock);
    stray_sd = 1'b0;
    repeat (2) @(negedge clock);
    set_cmd(0, 1'b1, 1'b0, 12'h5A5, 16'hBEEF);
    sd_delay = 3;
    push_grant(3'b001, 0); push_cmd(1'b1, 1'b0, 12'h5A5, 16'hBEEF); push_done(3'b001, 4, 1'b0);
    req = 3'b001;
    @(negedge clock) stray_sd = 1'b1;
    @(negedge clock) stray_sd = 1'b0;
    wait_done();
    req = 3'b000;
    repeat (2) @(negedge clock);

    // Reset mid-BUSY: outputs drop without a clock edge, no done.
    set_cmd(1, 1'b0, 1'b1, 12'h7E7, 16'hCAFE);
    sd_delay = 0;
    push_grant(3'b010, 1); push_cmd(1'b0, 1'b1, 12'h7E7, 16'hCAFE);
    req = 3'b010;
    repeat (3) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    chk("midrst_grant", 64'(grant), 64'd0);
    chk("midrst_valid", 64'(bus_valid), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    chk("midrst_owner", 64'(bus_owner), 64'd0);
    @(negedge clock) req = 3'b000;
    @(negedge clock) reset = 1'b0;
    set_cmd(0, 1'b0, 1'b1, 12'h0F0, 16'h0F0F);
    sd_delay = 1;
    push_grant(3'b001, 0); push_cmd(1'b0, 1'b1, 12'h0F0, 16'h0F0F); push_done(3'b001, 2, 1'b0);
    req = 3'b111;
    wait_done();
    req = 3'b000;
    repeat (3) @(negedge clock);

`ifdef ARB_TIMEOUT_EN
    // Abort after 4 BUSY cycles, then next requester; its snoop_done lands
    // in the final counted cycle and wins over the timeout.
    set_cmd(2, 1'b1, 1'b0, 12'hFFF, 16'hFFFF);
    sd_delay = 0;
    push_grant(3'b100, 2); push_cmd(1'b1, 1'b0, 12'hFFF, 16'hFFFF); push_done(3'b100, 5, 1'b1);
    push_grant(3'b001, 0); push_cmd(1'b0, 1'b1, 12'h0F0, 16'h0F0F); push_done(3'b001, 5, 1'b0);
    req = 3'b101;
    wait_done();
    req = 3'b001;
    sd_delay = 4;
    wait_done();
    req = 3'b000;
`else
    // Without the timeout, BUSY outlasts TIMEOUT until snoop_done arrives.
    set_cmd(2, 1'b1, 1'b0, 12'hFFF, 16'hFFFF);
    sd_delay = 20;
    push_grant(3'b100, 2); push_cmd(1'b1, 1'b0, 12'hFFF, 16'hFFFF); push_done(3'b100, 21, 1'b0);
    req = 3'b100;
    wait_done();
    req = 3'b000;
`endif
    repeat (4) @(negedge clock);
    chk("queue_drained", 64'(exq.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
